// File: rtl/stopwatch_lap.sv
// BCD mm:ss stopwatch with a tick prescaler, a run/pause/idle command FSM and a
// first-word-fall-through lap FIFO with pop handshake, wrap and drop status.
module stopwatch_lap #(
  parameter int TICK_DIV = 25000000,
  parameter int MIN_MAX  = 99,
  parameter int LAP_AW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cmd,
  output logic [1:0]        state,
  output logic [15:0]       time_bcd,
  output logic              wrap,
  output logic [15:0]       lap_data,
  output logic              lap_empty,
  output logic              lap_full,
  output logic [LAP_AW:0]   lap_count,
  input  logic              lap_rd,
  output logic              lap_drop
);

  localparam int DEPTH = 1 << LAP_AW;
  localparam int PW    = $clog2(TICK_DIV);
  localparam int CW    = LAP_AW + 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]    MIN_LAST   = 7'(MIN_MAX);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  localparam logic [2:0] CMD_START = 3'b001;
  localparam logic [2:0] CMD_STOP  = 3'b010;
  localparam logic [2:0] CMD_LAP   = 3'b100;
  localparam logic [2:0] CMD_ZERO  = 3'b011;
  localparam logic [2:0] CMD_CLR   = 3'b111;

  // One-second BCD increment; bit 16 flags the MIN_MAX:59 -> 00:00 rollover.
  function automatic logic [16:0] time_next(input logic [15:0] t);
    logic [6:0]  mins;
    logic [16:0] r;
    mins = 7'(t[15:12]) * 7'd10 + 7'(t[11:8]);
    r    = {1'b0, t};
    if (mins == MIN_LAST && t[7:4] == 4'd5 && t[3:0] == 4'd9) begin
      r = {1'b1, 16'h0000};
    end else if (t[3:0] != 4'd9) begin
      r[3:0] = t[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd5) begin
        r[7:4] = t[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (t[11:8] != 4'd9) begin
          r[11:8] = t[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = t[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [15:0]       time_q, time_d;
  logic              wrap_q, wrap_d;
  logic [LAP_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LAP_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              drop_q, drop_d;
  logic [15:0]       head_q, head_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic [15:0]       mem_q [DEPTH];

  logic              tick_s;
  logic              push_s;
  logic              pop_s;
  logic              wr_en_s;
  logic              clear_s;
  logic [16:0]       adv_s;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    time_d  = time_q;
    wrap_d  = wrap_q;
    push_s  = 1'b0;
    adv_s   = time_next(time_q);
    tick_s  = (state_q == S_RUN) && (presc_q == PRESC_LAST);

    if (tick_s) begin
      presc_d = '0;
      time_d  = adv_s[15:0];
      wrap_d  = wrap_q | adv_s[16];
    end else if (state_q == S_RUN) begin
      presc_d = presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end

    // Lap always captures time_q, so a same-cycle tick never leaks into the entry.
    case (state_q)
      S_IDLE: begin
        case (cmd)
          CMD_START: state_d = S_RUN;
          CMD_ZERO: begin
            time_d  = 16'h0000;
            presc_d = '0;
            wrap_d  = 1'b0;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_RUN: begin
        case (cmd)
          CMD_STOP: state_d = S_PAUSE;
          CMD_LAP:  push_s  = 1'b1;
          default:  state_d = S_RUN;
        endcase
      end
      S_PAUSE: begin
        case (cmd)
          CMD_START: state_d = S_RUN;
          CMD_LAP:   push_s  = 1'b1;
          CMD_ZERO: begin
            state_d = S_IDLE;
            time_d  = 16'h0000;
            presc_d = '0;
            wrap_d  = 1'b0;
          end
          default: state_d = S_PAUSE;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clear_s  = (cmd == CMD_CLR);
    pop_s    = lap_rd && !empty_q;
    wr_en_s  = push_s && (!full_q || pop_s);
    drop_d   = drop_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_d   = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + LAP_AW'(wr_en_s);
      rd_ptr_d = rd_ptr_q + LAP_AW'(pop_s);
      count_d  = count_q + CW'(wr_en_s) - CW'(pop_s);
      drop_d   = drop_q | (push_s && full_q && !pop_s);
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == COUNT_FULL);
    // The next head may be the entry being written this very cycle (push into empty).
    if (empty_d) begin
      head_d = 16'h0000;
    end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = time_q;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      time_q   <= 16'h0000;
      wrap_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
      head_q   <= 16'h0000;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      time_q   <= time_d;
      wrap_q   <= wrap_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      head_q   <= head_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_q[wr_ptr_q] <= time_q;
    end
  end

  assign state     = state_q;
  assign time_bcd  = time_q;
  assign wrap      = wrap_q;
  assign lap_data  = head_q;
  assign lap_empty = empty_q;
  assign lap_full  = full_q;
  assign lap_count = count_q;
  assign lap_drop  = drop_q;

endmodule
